// File: rtl/ifetch_queue.sv
// Fetch-stage prefetch queue: owns fetch PC, reads a 1-cycle sync imem, buffers {instr, pc}.
// Issue-to-visible latency 2 cycles; requests are credit-limited so out_ready=0 stalls fetch without loss.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_rdata,
   output logic                     out_valid,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t            entries [DEPTH];
   logic [31:0]       fetch_pc;
   logic [31:0]       inflight_pc;
   logic              inflight;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic [AW+1:0]     credit_used;
   logic              push;
   logic              pop;

   // An outstanding read already owns a slot, so it counts against the free space.
   always_comb begin
      credit_used = {1'b0, count} + {{(AW + 1){1'b0}}, inflight};
      imem_req    = rst & ~redirect & (credit_used < (AW + 2)'(DEPTH));
      push        = inflight & ~redirect;
      out_valid   = (count != '0) & ~redirect;
      pop         = out_valid & out_ready;
   end

   assign imem_addr = fetch_pc;
   assign out_instr = entries[rd_ptr].instr;
   assign out_pc    = entries[rd_ptr].pc;
   assign occupancy = count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         inflight_pc <= '0;
         inflight    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (redirect) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (imem_req) begin
            fetch_pc    <= fetch_pc + 32'd4;
            inflight_pc <= fetch_pc;
         end
         inflight <= imem_req;
         if (push) begin
            entries[wr_ptr] <= '{instr: imem_rdata, pc: inflight_pc};
            wr_ptr          <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
      !(push && (count == (AW + 1)'(DEPTH))));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: sync memory model plus an expected-PC scoreboard checked at every pop.
module tb_ifetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready = 1'b0;
   logic [2:0]  occupancy;

   int tests_run = 0;
   int tests_failed = 0;
   logic [31:0] exp_q [$];
   logic [31:0] nxt = 32'h0000_3000;
   logic [31:0] exp_pc;

   ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_5A00;
   endfunction

   always @(posedge clk) if (imem_req) imem_rdata <= mem_fn(imem_addr);

   task automatic restart(input logic [31:0] base);
      exp_q.delete();
      nxt = base;
   endtask

   // Drive one cycle's inputs at the falling edge, then settle before sampling.
   task automatic cyc(input logic r, input logic rdy, input logic redir, input logic [31:0] rpc);
      @(negedge clk);
      rst = r; out_ready = rdy; redirect = redir; redirect_pc = rpc;
      if (redir) restart({rpc[31:2], 2'b00});
      while (exp_q.size() < 4) begin
         exp_q.push_back(nxt);
         nxt = nxt + 32'd4;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 32'h0);
         tests_run++;
         if (imem_req !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd0 ||
             out_pc !== 32'h0 || out_instr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset: req=%b vld=%b occ=%0d pc=%h instr=%h, want 0/0/0/0/0",
                     imem_req, out_valid, occupancy, out_pc, out_instr);
         end
      end
   endtask

   task automatic test_stream();
      restart(32'h3000);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
         tests_run++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h3000 + 32'(4 * i) || out_valid !== (i >= 2)) begin
            tests_failed++;
            $display("FAIL stream[%0d]: req=%b addr=%h vld=%b, want 1 %h %b",
                     i, imem_req, imem_addr, out_valid, 32'h3000 + 32'(4 * i), (i >= 2));
         end
         if (out_valid && out_ready) begin
            exp_pc = exp_q.pop_front();
            tests_run++;
            if (out_pc !== exp_pc || out_instr !== mem_fn(exp_pc)) begin
               tests_failed++;
               $display("FAIL stream_deliver: pc=%h instr=%h, want %h %h", out_pc, out_instr, exp_pc, mem_fn(exp_pc));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      int d = 0;
      bit seen = 0;
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      restart(32'h3000);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 32'h0);
         if (imem_req) begin
            tests_run++;
            if (imem_addr !== 32'h3000 + 32'(4 * n)) begin
               tests_failed++;
               $display("FAIL bp_req_addr: got %h, want %h", imem_addr, 32'h3000 + 32'(4 * n));
            end
            n++;
         end
      end
      tests_run++;
      if (n != 4 || occupancy !== 3'd4 || out_valid !== 1'b1 || out_pc !== 32'h3000) begin
         tests_failed++;
         $display("FAIL bp_full: reqs=%0d occ=%0d vld=%b pc=%h, want 4 4 1 00003000", n, occupancy, out_valid, out_pc);
      end
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
         if (imem_req && !seen) begin
            seen = 1;
            tests_run++;
            if (imem_addr !== 32'h3010) begin
               tests_failed++;
               $display("FAIL bp_resume_addr: got %h, want 00003010", imem_addr);
            end
         end
         if (out_valid && out_ready) begin
            exp_pc = exp_q.pop_front();
            d++;
            tests_run++;
            if (out_pc !== exp_pc || out_instr !== mem_fn(exp_pc)) begin
               tests_failed++;
               $display("FAIL bp_deliver: pc=%h instr=%h, want %h %h", out_pc, out_instr, exp_pc, mem_fn(exp_pc));
            end
         end
      end
      tests_run++;
      if (d != 12) begin
         tests_failed++;
         $display("FAIL bp_count: delivered %0d, want 12", d);
      end
   endtask

   task automatic test_redirect();
      int d = 0;
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      restart(32'h3000);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 1'b1, 32'h3040);
      tests_run++;
      if (occupancy !== 3'd3 || out_valid !== 1'b0 || imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL redir_cycle: occ=%0d vld=%b req=%b, want 3 0 0", occupancy, out_valid, imem_req);
      end
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
         if (i < 2) begin
            tests_run++;
            if (out_valid !== 1'b0) begin
               tests_failed++;
               $display("FAIL redir_bubble[%0d]: vld=%b, want 0", i, out_valid);
            end
         end
         if (out_valid && out_ready) begin
            exp_pc = exp_q.pop_front();
            d++;
            tests_run++;
            if (out_pc !== exp_pc || out_instr !== mem_fn(exp_pc)) begin
               tests_failed++;
               $display("FAIL redir_deliver: pc=%h instr=%h, want %h %h", out_pc, out_instr, exp_pc, mem_fn(exp_pc));
            end
         end
      end
      tests_run++;
      if (d != 6) begin
         tests_failed++;
         $display("FAIL redir_count: delivered %0d, want 6", d);
      end
   endtask

   task automatic test_redirect_align();
      int d = 0;
      cyc(1'b1, 1'b1, 1'b1, 32'h3043);
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h3040) begin
         tests_failed++;
         $display("FAIL align: req=%b addr=%h, want 1 00003040", imem_req, imem_addr);
      end
      cyc(1'b1, 1'b1, 1'b1, 32'h3100);
      cyc(1'b1, 1'b1, 1'b1, 32'h3200);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
         if (out_valid && out_ready) begin
            exp_pc = exp_q.pop_front();
            tests_run++;
            if (d == 0 && out_pc !== 32'h3200) begin
               tests_failed++;
               $display("FAIL b2b_first: pc=%h, want 00003200", out_pc);
            end else if (out_pc !== exp_pc || out_instr !== mem_fn(exp_pc)) begin
               tests_failed++;
               $display("FAIL b2b_deliver: pc=%h instr=%h, want %h %h", out_pc, out_instr, exp_pc, mem_fn(exp_pc));
            end
            d++;
         end
      end
      tests_run++;
      if (d != 4) begin
         tests_failed++;
         $display("FAIL b2b_count: delivered %0d, want 4", d);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if (occupancy !== 3'd4) begin
         tests_failed++;
         $display("FAIL rstmid_fill: occ=%0d, want 4", occupancy);
      end
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      tests_run++;
      if (imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_req: req=%b, want 0", imem_req);
      end
      restart(32'h3000);
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      tests_run++;
      if (occupancy !== 3'd0 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
         tests_failed++;
         $display("FAIL rstmid_after: occ=%0d vld=%b req=%b addr=%h, want 0 0 1 00003000",
                  occupancy, out_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_random();
      logic        r;
      logic        rdy;
      logic [31:0] rpc;
      for (int i = 0; i < 1000; i++) begin
         r   = ($urandom_range(0, 99) < 3);
         rdy = 1'($urandom_range(0, 1));
         rpc = 32'h3000 + 32'($urandom_range(0, 1023));
         cyc(1'b1, rdy, r, rpc);
         tests_run++;
         if (occupancy > 3'd4) begin
            tests_failed++;
            $display("FAIL rand_occ[%0d]: occ=%0d, want <=4", i, occupancy);
         end
         if (out_valid && out_ready) begin
            exp_pc = exp_q.pop_front();
            tests_run++;
            if (out_pc !== exp_pc || out_instr !== mem_fn(exp_pc)) begin
               tests_failed++;
               $display("FAIL rand_deliver[%0d]: pc=%h instr=%h, want %h %h", i, out_pc, out_instr, exp_pc, mem_fn(exp_pc));
            end
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_align();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
